mold_message_splitter: RTL and testbench
========================================

// Module: mold_message_splitter
// PURPOSE
//   Downstream companion of the MoldUDP64 header decoder. Counts 64-bit beats of each packet,
//   drives the beat index the decoder samples, and skips the header words. Splits the payload
//   into length-prefixed message blocks and emits ITCH message bytes, one byte per cycle,
//   with start/end-of-message framing to the ITCH message parser.
// PARAMETERS
//   HDR_WORDS  8  beats before payload; payload byte 0 = beat HDR_WORDS, lane 0
//   WCNT_W     4  width of beat index output; saturates at all-ones
// PORTS
//   clk          in   1   clock
//   rst          in   1   reset: synchronous, active-high
//   s_data       in   64  packet beat; stream byte k in s_data[8k+7:8k]
//   s_valid      in   1   beat valid
//   s_last       in   1   final beat of packet
//   s_ready      out  1   beat accepted when s_valid & s_ready
//   msg_count    in   16  MoldUDP64 message count from decoder, sampled on first payload beat
//   word_idx     out  W   index of beat now on s_data (decoder 'counter' input)
//   m_byte       out  8   message byte
//   m_valid      out  1   m_byte valid
//   m_ready      in   1   downstream accepts byte when m_valid & m_ready
//   m_som        out  1   first byte of message (qualified by m_valid)
//   m_eom        out  1   last byte of message (qualified by m_valid)
//   m_msg_len    out  16  length of current message, stable from m_som through m_eom
//   m_msg_idx    out  16  0-based message index within packet
//   err_runt     out  1   1-cycle pulse: s_last accepted before payload reached
//   err_trunc    out  1   1-cycle pulse: packet ended inside length field or message body
// BEHAVIOUR
//   Reset: all regs cleared next edge; s_ready=1, word_idx=0, m_valid=0, m_som=m_eom=0,
//     m_msg_len=0, m_msg_idx=0, errs=0, state HDR. Reset mid-message abandons it (no m_eom).
//   word_idx: +1 per accepted beat, saturating; 0 after accepting an s_last beat.
//   States: HDR, LEN_HI, LEN_LO, BODY, DROP. One-beat hold reg (hold_data, hold_last, byte ptr 0..7).
//   HDR: s_ready=1; beats discarded. Accepting beat HDR_WORDS-1 -> LEN_HI; s_last there -> err_runt, HDR.
//   Payload beats: s_ready = !hold_valid; accepted beat loads hold, ptr=0; bytes processed from
//     next cycle. ptr 7 consumed -> hold_valid clears (1 bubble/beat is allowed).
//   First payload beat: msg_left <= msg_count; if 0 (heartbeat) -> DROP immediately.
//   LEN_HI/LEN_LO: consume 1 byte/cycle unconditionally; big-endian length, byte at LEN_HI is MSB.
//     LEN_LO: len==0 -> msg_left--, m_msg_idx++, to LEN_HI (or DROP if msg_left hits 0); else BODY.
//   BODY: m_valid=hold_valid; byte consumed only on m_ready; m_som on first, m_eom when remaining==1.
//     m_valid/m_byte hold stable while m_ready=0. After m_eom accepted: msg_left--, m_msg_idx++;
//     msg_left==0 -> DROP else LEN_HI. Length field may straddle beats.
//   DROP: remaining hold bytes and beats discarded, s_ready=1, until s_last.
//   Packet end (hold_last and ptr 7 consumed): from DROP/LEN_HI -> HDR clean.
//     In LEN_LO -> err_trunc, HDR. In BODY with bytes remaining: that byte goes out with m_eom=1,
//     err_trunc pulses on its acceptance cycle, then HDR.
//   m_msg_idx resets to 0 on entering HDR. Latency: first payload byte m_valid one cycle after beat.
// STRUCTURE
//   Package mold_pkg: state enum, HDR_WORDS default, MOLD_LEN_BYTES=2, byte-lane extract function.
//   Sub-module mold_beat_hold: one-beat hold register + byte pointer, feeding the splitter FSM.
// TESTING
//   1 msg_count=2; beat8 = 00 03 A1 A2 A3 00 09 B1, beat9 (last) = B2..B9 -> 12 bytes,
//     som on A1/B1, eom on A3/B9, idx 0 then 1, len 3 then 9, no errors.
//   2 Same packet, m_ready toggling 1/0 each cycle -> identical byte sequence, no loss/dup.
//   3 msg_count=0, 3 payload beats -> zero m_valid, all beats accepted, word_idx back to 0.
//   4 msg_count=2, payload 00 00 00 02 C1 C2 + pad -> first len 0 skipped, one msg idx 1 len 2.
//   5 msg_count=1, len=0x0010, s_last after 6 body bytes -> last byte m_eom=1, err_trunc pulse.
//   6 s_last on beat 4 -> err_runt pulse, next packet parsed normally; rst asserted mid-BODY ->
//     m_valid=0 next cycle, word_idx=0.

Source files
------------

// File: rtl/mold_message_splitter_pkg.sv
// mold_pkg: shared definitions for the MoldUDP64 message splitter.
//   HDR_WORDS_DEFAULT : number of 64-bit header beats ahead of the payload
//   MOLD_LEN_BYTES    : width in bytes of each message-block length prefix
//   LEN_W             : length prefix width in bits
//   state_t / ST_*    : splitter FSM state encoding
//   lane_byte()       : pick byte lane 0..7 out of a 64-bit beat
package mold_pkg;

  localparam int HDR_WORDS_DEFAULT = 8;
  localparam int MOLD_LEN_BYTES    = 2;
  localparam int LEN_W             = 8 * MOLD_LEN_BYTES;

  typedef logic [2:0] state_t;

  localparam state_t ST_HDR    = 3'd0;
  localparam state_t ST_LEN_HI = 3'd1;
  localparam state_t ST_LEN_LO = 3'd2;
  localparam state_t ST_BODY   = 3'd3;
  localparam state_t ST_DROP   = 3'd4;

  // Stream byte k of a beat lives in data[8k+7:8k].
  function automatic logic [7:0] lane_byte(input logic [63:0] data, input logic [2:0] lane);
    return data[{lane, 3'b000} +: 8];
  endfunction

endpackage

// File: rtl/mold_message_splitter_if.sv
// mold_message_splitter_if: byte-wide ITCH message stream with framing.
//   m_byte     : message byte
//   m_valid    : m_byte valid
//   m_ready    : sink accepts byte when m_valid & m_ready
//   m_som      : first byte of message
//   m_eom      : last byte of message
//   m_msg_len  : length of the current message
//   m_msg_idx  : 0-based message index within the packet
// modport master = splitter side, modport slave = message parser side.
interface mold_message_splitter_if;
  import mold_pkg::*;

  logic [7:0]       m_byte;
  logic             m_valid;
  logic             m_ready;
  logic             m_som;
  logic             m_eom;
  logic [LEN_W-1:0] m_msg_len;
  logic [15:0]      m_msg_idx;

  modport master (
    output m_byte, m_valid, m_som, m_eom, m_msg_len, m_msg_idx,
    input  m_ready
  );

  modport slave (
    input  m_byte, m_valid, m_som, m_eom, m_msg_len, m_msg_idx,
    output m_ready
  );

endinterface

// File: rtl/mold_message_splitter_beat_hold.sv
// mold_beat_hold: one-beat holding register with a byte pointer.
//   clk, rst    : clock, synchronous active-high reset
//   flush       : discard the held beat
//   load        : capture load_data/load_last, pointer to lane 0
//   consume     : current byte used; advance pointer, empty after lane 7
//   hold_valid  : a beat is held
//   hold_last   : held beat is the packet's final beat
//   hold_byte   : byte at the current pointer
//   ptr_last    : pointer is on lane 7
module mold_beat_hold
  import mold_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        load,
  input  logic [63:0] load_data,
  input  logic        load_last,
  input  logic        consume,
  output logic        hold_valid,
  output logic        hold_last,
  output logic [7:0]  hold_byte,
  output logic        ptr_last
);

  logic [63:0] data_reg;
  logic        last_reg;
  logic        valid_reg;
  logic [2:0]  ptr_reg;

  always_ff @(posedge clk) begin
    if (rst) begin
      data_reg  <= '0;
      last_reg  <= 1'b0;
      valid_reg <= 1'b0;
      ptr_reg   <= '0;
    end else if (flush) begin
      valid_reg <= 1'b0;
    end else if (load) begin
      data_reg  <= load_data;
      last_reg  <= load_last;
      valid_reg <= 1'b1;
      ptr_reg   <= '0;
    end else if (consume) begin
      if (ptr_reg == 3'd7) begin
        valid_reg <= 1'b0;
      end
      ptr_reg <= ptr_reg + 3'd1;
    end
  end

  assign hold_valid = valid_reg;
  assign hold_last  = last_reg;
  assign hold_byte  = lane_byte(data_reg, ptr_reg);
  assign ptr_last   = (ptr_reg == 3'd7);

endmodule

// File: rtl/mold_message_splitter.sv
// mold_message_splitter: skips the MoldUDP64 header beats, then walks the
// payload as length-prefixed message blocks and emits message bytes one per
// cycle with start/end-of-message framing.
//   clk, rst            : clock, synchronous active-high reset
//   s_data/s_valid/s_last/s_ready : 64-bit packet beat stream in
//   msg_count           : message count from the header decoder, taken on the first payload beat
//   word_idx            : index of the beat currently on s_data (saturating)
//   msg                 : message byte stream out (master modport)
//   err_runt            : pulse, packet ended inside the header
//   err_trunc           : pulse, packet ended inside a length field or message body
// word_idx also drives header detection, so HDR_WORDS-1 must fit below its
// saturation value.
module mold_message_splitter
  import mold_pkg::*;
#(
  parameter int HDR_WORDS = HDR_WORDS_DEFAULT,
  parameter int WCNT_W    = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [63:0]           s_data,
  input  logic                  s_valid,
  input  logic                  s_last,
  output logic                  s_ready,
  input  logic [15:0]           msg_count,
  output logic [WCNT_W-1:0]     word_idx,
  mold_message_splitter_if.master msg,
  output logic                  err_runt,
  output logic                  err_trunc
);

  localparam logic [WCNT_W-1:0] HDR_LAST_IDX = WCNT_W'(HDR_WORDS - 1);

  state_t            state_reg, state_next;
  logic [WCNT_W-1:0] word_idx_reg;
  logic              first_reg;
  logic [15:0]       msg_left_reg;
  logic [7:0]        len_hi_reg;
  logic [LEN_W-1:0]  len_reg;
  logic [LEN_W-1:0]  rem_reg;
  logic [15:0]       msg_idx_reg;

  logic              hold_valid, hold_last, ptr_last;
  logic [7:0]        hold_byte;
  logic              in_payload, s_acc, hold_load, consume, flush, eop, body_last;
  logic              msg_done, start_body, trunc, runt;
  logic [LEN_W-1:0]  len_word;

  mold_beat_hold u_hold (
    .clk        (clk),
    .rst        (rst),
    .flush      (flush),
    .load       (hold_load),
    .load_data  (s_data),
    .load_last  (s_last),
    .consume    (consume),
    .hold_valid (hold_valid),
    .hold_last  (hold_last),
    .hold_byte  (hold_byte),
    .ptr_last   (ptr_last)
  );

  assign in_payload = (state_reg == ST_LEN_HI) || (state_reg == ST_LEN_LO) || (state_reg == ST_BODY);

  // In DROP, hold off the next packet's first beat until the held final beat is gone.
  assign s_ready = in_payload ? !hold_valid :
                   (state_reg == ST_DROP) ? !(hold_valid && hold_last) : 1'b1;

  assign s_acc     = s_valid && s_ready;
  assign hold_load = s_acc && in_payload;
  assign flush     = (state_reg == ST_DROP);
  assign consume   = hold_valid && ((state_reg == ST_LEN_HI) || (state_reg == ST_LEN_LO) ||
                                    ((state_reg == ST_BODY) && msg.m_ready));
  assign eop       = consume && hold_last && ptr_last;
  assign len_word  = {len_hi_reg, hold_byte};
  // Final byte of a message, either by its length or by the packet running out.
  assign body_last = (rem_reg == LEN_W'(1)) || (hold_last && ptr_last);

  always_comb begin
    state_next = state_reg;
    msg_done   = 1'b0;
    start_body = 1'b0;
    trunc      = 1'b0;
    runt       = 1'b0;
    case (state_reg)
      ST_HDR: begin
        if (s_acc) begin
          if (s_last) begin
            runt = 1'b1;
          end else if (word_idx_reg == HDR_LAST_IDX) begin
            state_next = ST_LEN_HI;
          end
        end
      end
      ST_LEN_HI: begin
        // Heartbeat packet: nothing to split, discard the rest.
        if (first_reg && hold_load && (msg_count == 16'd0)) begin
          state_next = ST_DROP;
        end else if (consume) begin
          state_next = eop ? ST_HDR : ST_LEN_LO;
        end
      end
      ST_LEN_LO: begin
        if (consume) begin
          if (eop) begin
            trunc      = 1'b1;
            state_next = ST_HDR;
          end else if (len_word == '0) begin
            msg_done   = 1'b1;
            state_next = (msg_left_reg == 16'd1) ? ST_DROP : ST_LEN_HI;
          end else begin
            start_body = 1'b1;
            state_next = ST_BODY;
          end
        end
      end
      ST_BODY: begin
        if (consume && body_last) begin
          if (rem_reg != LEN_W'(1)) begin
            trunc      = 1'b1;
            state_next = ST_HDR;
          end else begin
            msg_done = 1'b1;
            if (eop) begin
              state_next = ST_HDR;
            end else if (msg_left_reg == 16'd1) begin
              state_next = ST_DROP;
            end else begin
              state_next = ST_LEN_HI;
            end
          end
        end
      end
      ST_DROP: begin
        if (hold_valid && hold_last) begin
          state_next = ST_HDR;
        end else if (s_acc && s_last) begin
          state_next = ST_HDR;
        end
      end
      default: state_next = ST_HDR;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg    <= ST_HDR;
      word_idx_reg <= '0;
      first_reg    <= 1'b0;
      msg_left_reg <= '0;
      len_hi_reg   <= '0;
      len_reg      <= '0;
      rem_reg      <= '0;
      msg_idx_reg  <= '0;
    end else begin
      state_reg <= state_next;

      if (s_acc) begin
        if (s_last) begin
          word_idx_reg <= '0;
        end else if (!(&word_idx_reg)) begin
          word_idx_reg <= word_idx_reg + 1'b1;
        end
      end

      if ((state_reg == ST_HDR) && (state_next == ST_LEN_HI)) begin
        first_reg <= 1'b1;
      end else if (hold_load) begin
        first_reg <= 1'b0;
      end

      if (first_reg && hold_load) begin
        msg_left_reg <= msg_count;
      end else if (msg_done) begin
        msg_left_reg <= msg_left_reg - 16'd1;
      end

      if (consume && (state_reg == ST_LEN_HI)) begin
        len_hi_reg <= hold_byte;
      end

      if (start_body) begin
        len_reg <= len_word;
        rem_reg <= len_word;
      end else if (consume && (state_reg == ST_BODY)) begin
        rem_reg <= rem_reg - LEN_W'(1);
      end

      if (state_next == ST_HDR) begin
        msg_idx_reg <= '0;
      end else if (msg_done) begin
        msg_idx_reg <= msg_idx_reg + 16'd1;
      end
    end
  end

  assign word_idx      = word_idx_reg;
  assign msg.m_valid   = (state_reg == ST_BODY) && hold_valid;
  assign msg.m_byte    = hold_byte;
  assign msg.m_som     = msg.m_valid && (rem_reg == len_reg);
  assign msg.m_eom     = msg.m_valid && body_last;
  assign msg.m_msg_len = len_reg;
  assign msg.m_msg_idx = msg_idx_reg;
  assign err_runt      = runt;
  assign err_trunc     = trunc;

endmodule

// File: tb/tb_mold_message_splitter.sv
// Directed bench for mold_message_splitter: stimulus pushes expected bytes
// into a scoreboard queue; a negedge monitor pops and compares on every
// accepted output byte.
module tb_mold_message_splitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [63:0] s_data;
  logic        s_valid;
  logic        s_last;
  logic        s_ready;
  logic [15:0] msg_count;
  logic [3:0]  word_idx;
  logic        err_runt;
  logic        err_trunc;

  mold_message_splitter_if bus ();

  always #5 clk = ~clk;

  mold_message_splitter #(.HDR_WORDS(8), .WCNT_W(4)) dut (
    .clk       (clk),
    .rst       (rst),
    .s_data    (s_data),
    .s_valid   (s_valid),
    .s_last    (s_last),
    .s_ready   (s_ready),
    .msg_count (msg_count),
    .word_idx  (word_idx),
    .msg       (bus.master),
    .err_runt  (err_runt),
    .err_trunc (err_trunc)
  );

  typedef struct packed {
    logic [7:0]  b;
    logic        som;
    logic        eom;
    logic [15:0] len;
    logic [15:0] idx;
    logic        trunc;
  } exp_t;

  exp_t        q[$];
  exp_t        e;
  int          vectors = 0;
  int          miscompares = 0;
  int          runt_cnt = 0;
  int          trunc_cnt = 0;
  int          ready_mode = 0;  // 0: always ready, 1: toggle, 2: stalled
  logic        prev_stall = 1'b0;
  logic [7:0]  prev_byte = 8'h00;
  logic [63:0] pay[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail(input string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: got timeout/unexpected expected none", name);
  endtask

  task automatic push(input logic [7:0] b, input logic som, input logic eom,
                      input logic [15:0] len, input logic [15:0] idx, input logic trunc);
    exp_t x;
    x = '{b: b, som: som, eom: eom, len: len, idx: idx, trunc: trunc};
    q.push_back(x);
  endtask

  // m_ready pattern, updated just after each rising edge.
  always @(posedge clk) begin
    #1;
    case (ready_mode)
      1:       bus.m_ready = ~bus.m_ready;
      2:       bus.m_ready = 1'b0;
      default: bus.m_ready = 1'b1;
    endcase
  end

  // Monitor: sees each transfer half a cycle before the edge that completes it.
  always @(negedge clk) begin
    if (rst) begin
      prev_stall <= 1'b0;
    end else begin
      if (prev_stall) begin
        chk("hold_stable", {23'd0, bus.m_valid, bus.m_byte}, {23'd0, 1'b1, prev_byte});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (q.size() == 0) begin
          fail("unexpected_byte");
        end else begin
          e = q.pop_front();
          $display("byte %02h som=%0d eom=%0d len=%0d idx=%0d", bus.m_byte, bus.m_som,
                   bus.m_eom, bus.m_msg_len, bus.m_msg_idx);
          chk("m_byte", {24'd0, bus.m_byte}, {24'd0, e.b});
          chk("m_som", {31'd0, bus.m_som}, {31'd0, e.som});
          chk("m_eom", {31'd0, bus.m_eom}, {31'd0, e.eom});
          chk("m_msg_len", {16'd0, bus.m_msg_len}, {16'd0, e.len});
          chk("m_msg_idx", {16'd0, bus.m_msg_idx}, {16'd0, e.idx});
          chk("err_trunc_at_byte", {31'd0, err_trunc}, {31'd0, e.trunc});
        end
      end
      prev_stall <= bus.m_valid && !bus.m_ready;
      prev_byte  <= bus.m_byte;
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      if (err_runt)  runt_cnt  <= runt_cnt + 1;
      if (err_trunc) trunc_cnt <= trunc_cnt + 1;
    end
  end

  // Present one beat and hold it until accepted; exp_idx < 0 skips the word_idx check.
  task automatic send_beat(input logic [63:0] d, input logic last, input int exp_idx);
    int n;
    n = 0;
    s_data  = d;
    s_valid = 1'b1;
    s_last  = last;
    @(negedge clk);
    if (exp_idx >= 0) chk("word_idx", {28'd0, word_idx}, exp_idx[31:0]);
    while (!s_ready && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!s_ready) fail("beat_accept_timeout");
    @(posedge clk);
    #1;
    s_valid = 1'b0;
    s_last  = 1'b0;
  endtask

  // 8 header beats then the beats queued in pay; last payload beat carries s_last.
  task automatic send_packet(input logic [15:0] cnt, input logic end_pkt);
    msg_count = cnt;
    for (int i = 0; i < 8; i++) send_beat(64'hDEAD_0000_0000_0000 | 64'(i), 1'b0, i);
    for (int j = 0; j < pay.size(); j++) begin
      send_beat(pay[j], end_pkt && (j == pay.size() - 1), (8 + j < 15) ? 8 + j : -1);
    end
    if (end_pkt) begin
      @(negedge clk);
      chk("word_idx_after_pkt", {28'd0, word_idx}, 32'd0);
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_drain(input string name);
    int n;
    n = 0;
    while (q.size() != 0 && n < 300) begin
      @(posedge clk);
      n++;
    end
    if (q.size() != 0) begin
      fail(name);
      q.delete();
    end
    repeat (4) @(posedge clk);
    #1;
  endtask

  task automatic push_test1();
    push(8'hA1, 1, 0, 3, 0, 0);
    push(8'hA2, 0, 0, 3, 0, 0);
    push(8'hA3, 0, 1, 3, 0, 0);
    for (int i = 1; i <= 9; i++) begin
      push(8'hB0 + 8'(i), i == 1, i == 9, 9, 1, 0);
    end
    pay.delete();
    pay.push_back(64'hB1_09_00_A3_A2_A1_03_00);
    pay.push_back(64'hB9_B8_B7_B6_B5_B4_B3_B2);
  endtask

  initial begin
    rst       = 1'b1;
    s_data    = '0;
    s_valid   = 1'b0;
    s_last    = 1'b0;
    msg_count = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("rst_word_idx", {28'd0, word_idx}, 32'd0);
    chk("rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("rst_m_som", {31'd0, bus.m_som}, 32'd0);
    chk("rst_m_eom", {31'd0, bus.m_eom}, 32'd0);
    chk("rst_m_msg_len", {16'd0, bus.m_msg_len}, 32'd0);
    chk("rst_m_msg_idx", {16'd0, bus.m_msg_idx}, 32'd0);
    chk("rst_err_runt", {31'd0, err_runt}, 32'd0);
    chk("rst_err_trunc", {31'd0, err_trunc}, 32'd0);
    @(posedge clk);
    #1;

    // 1: two messages, second straddles beats
    ready_mode = 0;
    push_test1();
    send_packet(16'd2, 1'b1);
    wait_drain("t1_drain");
    chk("t1_runt_cnt", runt_cnt, 32'd0);
    chk("t1_trunc_cnt", trunc_cnt, 32'd0);

    // 2: same packet under back-pressure
    ready_mode = 1;
    push_test1();
    send_packet(16'd2, 1'b1);
    wait_drain("t2_drain");
    ready_mode = 0;
    chk("t2_trunc_cnt", trunc_cnt, 32'd0);

    // 3: heartbeat, payload discarded
    pay.delete();
    pay.push_back(64'h1111_1111_1111_1111);
    pay.push_back(64'h2222_2222_2222_2222);
    pay.push_back(64'h3333_3333_3333_3333);
    send_packet(16'd0, 1'b1);
    wait_drain("t3_drain");

    // 4: zero-length block skipped, one real message at index 1
    push(8'hC1, 1, 0, 2, 1, 0);
    push(8'hC2, 0, 1, 2, 1, 0);
    pay.delete();
    pay.push_back(64'h5A_5A_C2_C1_02_00_00_00);
    send_packet(16'd2, 1'b1);
    wait_drain("t4_drain");
    chk("t4_trunc_cnt", trunc_cnt, 32'd0);

    // 5: body truncated after 6 of 16 bytes
    for (int i = 1; i <= 6; i++) push(8'hE0 + 8'(i), i == 1, i == 6, 16'h0010, 0, i == 6);
    pay.delete();
    pay.push_back(64'hE6_E5_E4_E3_E2_E1_10_00);
    send_packet(16'd1, 1'b1);
    wait_drain("t5_drain");
    chk("t5_trunc_cnt", trunc_cnt, 32'd1);
    chk("t5_runt_cnt", runt_cnt, 32'd0);

    // 6a: runt packet ending on beat 4, then a normal packet
    for (int i = 0; i < 4; i++) send_beat(64'hBEEF_0000_0000_0000 | 64'(i), i == 3, i);
    @(negedge clk);
    chk("t6_runt_cnt", runt_cnt, 32'd1);
    chk("t6_word_idx", {28'd0, word_idx}, 32'd0);
    @(posedge clk);
    #1;
    push_test1();
    send_packet(16'd2, 1'b1);
    wait_drain("t6_drain");
    chk("t6_runt_cnt_after", runt_cnt, 32'd1);
    chk("t6_trunc_cnt_after", trunc_cnt, 32'd1);

    // 6b: reset while a message byte is waiting
    ready_mode = 2;
    pay.delete();
    pay.push_back(64'hD6_D5_D4_D3_D2_D1_10_00);
    send_packet(16'd1, 1'b0);
    repeat (4) @(posedge clk);
    #1;
    @(negedge clk);
    chk("t6_stall_valid", {31'd0, bus.m_valid}, 32'd1);
    chk("t6_stall_byte", {24'd0, bus.m_byte}, 32'hD1);
    chk("t6_stall_som", {31'd0, bus.m_som}, 32'd1);
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    ready_mode = 0;
    @(negedge clk);
    chk("t6_rst_m_valid", {31'd0, bus.m_valid}, 32'd0);
    chk("t6_rst_word_idx", {28'd0, word_idx}, 32'd0);
    chk("t6_rst_s_ready", {31'd0, s_ready}, 32'd1);
    chk("t6_rst_m_eom", {31'd0, bus.m_eom}, 32'd0);
    repeat (4) @(posedge clk);
    #1;
    chk("queue_empty_end", q.size(), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
